axi_st_patchkr_top: RTL and testbench
=====================================

// Module: axi_st_patchkr_top
// PURPOSE
//  Downstream pattern checker for the AXIST dual pattern generator. Buffers the
//  generator's 40b-per-half expected words, expands each into the lane layout the
//  generator drives, and compares it against beats received over the AXIST link.
//  Reports beat/error counts and pass/done status to the test top.
// PARAMETERS
//  LEADER_MODE  1    1=FULL (256b beat, 40b exp word), 2=HALF (512b beat, 80b exp word)
//  FIFO_DEPTH   512  expected-word FIFO depth, power of 2
//  FIFO_AW      9    log2(FIFO_DEPTH)
// PORTS
//  clk             in   1                  single clock for all logic
//  rst_n           in   1                  asynchronous active-low reset
//  chkr_en         in   1                  level; high = run check, low = stop/return to idle
//  cntuspatt_en    in   1                  continuous mode: no beat limit, never DONE
//  patgen_cnt      in   9                  expected beat count (sampled on IDLE->RUN)
//  exp_din         in   LEADER_MODE*40     expected word from generator
//  exp_wr          in   1                  push exp_din
//  chkr_fifo_full  out  1                  expected FIFO full (back to generator)
//  axist_rx_data   in   LEADER_MODE*256    received beat
//  axist_rx_valid  in   1                  beat valid
//  axist_rx_rdy    out  1                  checker ready
//  beat_cnt        out  9                  beats accepted since run start
//  err_cnt         out  16                 mismatching beats, saturating
//  exp_ovf         out  1                  sticky: exp_wr while full
//  chkr_done       out  1                  level, high in DONE
//  chkr_pass       out  1                  valid when chkr_done: err_cnt==0 && !exp_ovf
// BEHAVIOUR
//  - Reset: all outputs 0, FIFO empty, state IDLE.
//  - Expansion: per 256b half h (h=0..LEADER_MODE-1), e=exp word bits [h*40+39:h*40];
//    lanes i=0..5 bits [h*256+i*40+39 : h*256+i*40] = e; bits [h*256+255:h*256+240] = e[15:0].
//  - FIFO: sync show-ahead, FIFO_DEPTH x LEADER_MODE*40. exp_wr accepted in every state;
//    exp_wr while full -> word dropped, exp_ovf set (cleared only on IDLE->RUN or reset).
//  - Handshake: axist_rx_rdy = (state==RUN) && !fifo_empty (combinational). Beat accepted
//    on rx_valid&&rx_rdy; the same cycle pops one FIFO word. rx_valid may stay high
//    while rdy is low; the beat is held, never counted twice.
//  - Pipeline: accepted at cycle N -> beat_cnt+1 and mismatch flag registered at N+1;
//    err_cnt+1 at N+2 if mismatch. err_cnt saturates at 16'hFFFF.
//  - FSM: IDLE --chkr_en--> RUN (clear beat_cnt, err_cnt, exp_ovf; latch patgen_cnt).
//    RUN --(!cntuspatt_en && accepted beat brings beat_cnt to latched cnt)--> DRAIN.
//    RUN with latched cnt==0 -> DRAIN next cycle, no beats accepted.
//    DRAIN (1 cycle, last err update lands) -> DONE. DONE: chkr_done=1, rdy=0.
//    any state --!chkr_en--> IDLE; leaving DONE flushes the FIFO; leaving RUN/DRAIN keeps
//    FIFO, counters hold their values, chkr_done stays 0.
//  - beat_cnt wraps mod 512 in continuous mode; err_cnt keeps counting.
//  - Reset mid-run: immediate return to reset state, in-flight compare discarded.
// CONFIGURATION
//  AXIST_CHKR_FIRST_ERR_EN defined: adds outputs first_err_data (LEADER_MODE*256) and
//   first_err_idx (9): received beat and beat index of first mismatch after IDLE->RUN,
//   captured at N+1, held until next IDLE->RUN; both 0 when no error.
//  Not defined: these ports and their capture registers do not exist; all else identical.
// TESTING
//  1 FULL, cnt=8, 8 matching incr words/beats -> done at N+2 after 8th beat, beat_cnt=8, err_cnt=0, pass=1.
//  2 Same, beat 3 bit 100 flipped -> err_cnt=1, pass=0; with macro first_err_idx=2.
//  3 FIFO empty while rx_valid high 5 cycles -> rdy=0, beat_cnt unchanged; push word -> accepted next cycle.
//  4 512 pushes then 1 more -> chkr_fifo_full=1, exp_ovf=1, pass=0 after run completes.
//  5 HALF, cnt=4, mismatch only in bits [511:496] of beat 0 -> err_cnt=1; cnt=0 -> done, pass=1, no beats.
//  6 cntuspatt_en=1, 600 matching beats -> beat_cnt=88, never done; rst_n low mid-run -> all outputs 0.

Source files
------------

// File: rtl/axi_st_patchkr_top.sv
// AXIST downstream pattern checker: expected-word FIFO, lane expansion, beat compare, counters.
// Optional first-error capture ports are enabled by defining AXIST_CHKR_FIRST_ERR_EN.
module axi_st_patchkr_top #(
    parameter int unsigned LEADER_MODE = 1,
    parameter int unsigned FIFO_DEPTH  = 512,
    parameter int unsigned FIFO_AW     = 9
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         chkr_en,
    input  logic                         cntuspatt_en,
    input  logic [8:0]                   patgen_cnt,
    input  logic [LEADER_MODE*40-1:0]    exp_din,
    input  logic                         exp_wr,
    output logic                         chkr_fifo_full,
    input  logic [LEADER_MODE*256-1:0]   axist_rx_data,
    input  logic                         axist_rx_valid,
    output logic                         axist_rx_rdy,
    output logic [8:0]                   beat_cnt,
    output logic [15:0]                  err_cnt,
    output logic                         exp_ovf,
    output logic                         chkr_done,
    output logic                         chkr_pass
`ifdef AXIST_CHKR_FIRST_ERR_EN
    ,
    output logic [LEADER_MODE*256-1:0]   first_err_data,
    output logic [8:0]                   first_err_idx
`endif
);

    localparam int unsigned EW = LEADER_MODE * 40;
    localparam int unsigned DW = LEADER_MODE * 256;
    localparam int unsigned PW = FIFO_AW + 1;
    localparam logic [PW-1:0] PTR_ONE = PW'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    state_t          state;
    state_t          state_d;
    logic            start;
    logic            flush;
    logic            accept;
    logic            last_beat;
    logic            zero_run;

    logic [EW-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr;
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr_d;
    logic [PW-1:0]   rd_ptr_d;
    logic            fifo_empty;
    logic            fifo_full;
    logic            push;
    logic [EW-1:0]   fifo_dout;

    logic [DW-1:0]   exp_beat;
    logic            mis_c;
    logic            mis_q;
    logic [8:0]      cnt_lat;
    logic [15:0]     err_d;
    logic            ovf_d;

    // Expected-word FIFO (show-ahead); words are accepted in every state
    assign fifo_empty     = (wr_ptr == rd_ptr);
    assign push           = exp_wr && !fifo_full;
    assign fifo_dout      = mem[rd_ptr[FIFO_AW-1:0]];
    assign chkr_fifo_full = fifo_full;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= exp_din;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr;
        rd_ptr_d = rd_ptr;
        if (push) begin
            wr_ptr_d = wr_ptr + PTR_ONE;
        end
        // A flush keeps any word written in the same cycle
        if (flush) begin
            rd_ptr_d = wr_ptr;
        end else if (accept) begin
            rd_ptr_d = rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            fifo_full <= 1'b0;
        end else begin
            wr_ptr    <= wr_ptr_d;
            rd_ptr    <= rd_ptr_d;
            fifo_full <= (wr_ptr_d[FIFO_AW] != rd_ptr_d[FIFO_AW]) &&
                         (wr_ptr_d[FIFO_AW-1:0] == rd_ptr_d[FIFO_AW-1:0]);
        end
    end

    // Replicate each 40b half-word across six lanes plus a 16b tail
    always_comb begin
        exp_beat = '0;
        for (int h = 0; h < int'(LEADER_MODE); h++) begin
            for (int i = 0; i < 6; i++) begin
                exp_beat[h*256 + i*40 +: 40] = fifo_dout[h*40 +: 40];
            end
            exp_beat[h*256 + 240 +: 16] = fifo_dout[h*40 +: 16];
        end
    end

    assign mis_c     = (axist_rx_data != exp_beat);
    assign accept    = axist_rx_valid && axist_rx_rdy;
    assign zero_run  = !cntuspatt_en && (cnt_lat == 9'd0);
    assign last_beat = accept && !cntuspatt_en && (9'(beat_cnt + 9'd1) == cnt_lat);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d      = state;
        start        = 1'b0;
        flush        = 1'b0;
        axist_rx_rdy = 1'b0;
        case (state)
            ST_IDLE: begin
                if (chkr_en) begin
                    state_d = ST_RUN;
                    start   = 1'b1;
                end
            end
            ST_RUN: begin
                axist_rx_rdy = !fifo_empty && !zero_run;
                if (!chkr_en) begin
                    state_d = ST_IDLE;
                end else if (zero_run || last_beat) begin
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                state_d = chkr_en ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                if (!chkr_en) begin
                    state_d = ST_IDLE;
                    flush   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Error counter saturates; a run start wins over a late mismatch
    always_comb begin
        err_d = err_cnt;
        ovf_d = exp_ovf;
        if (start) begin
            err_d = '0;
            ovf_d = 1'b0;
        end else if (mis_q && (err_cnt != 16'hFFFF)) begin
            err_d = err_cnt + 16'd1;
        end
        if (exp_wr && fifo_full) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            err_cnt   <= '0;
            exp_ovf   <= 1'b0;
            mis_q     <= 1'b0;
            cnt_lat   <= '0;
            chkr_done <= 1'b0;
            chkr_pass <= 1'b0;
        end else begin
            mis_q   <= accept && mis_c;
            err_cnt <= err_d;
            exp_ovf <= ovf_d;
            if (start) begin
                beat_cnt <= '0;
                cnt_lat  <= patgen_cnt;
            end else if (accept) begin
                beat_cnt <= 9'(beat_cnt + 9'd1);
            end
            chkr_done <= (state_d == ST_DONE);
            chkr_pass <= (state_d == ST_DONE) && (err_d == 16'd0) && !ovf_d;
        end
    end

`ifdef AXIST_CHKR_FIRST_ERR_EN
    logic err_seen;

    // Capture only the first mismatching beat of a run
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_seen       <= 1'b0;
            first_err_data <= '0;
            first_err_idx  <= '0;
        end else if (start) begin
            err_seen       <= 1'b0;
            first_err_data <= '0;
            first_err_idx  <= '0;
        end else if (accept && mis_c && !err_seen) begin
            err_seen       <= 1'b1;
            first_err_data <= axist_rx_data;
            first_err_idx  <= beat_cnt;
        end
    end
`endif

endmodule

// File: tb/tb_axi_st_patchkr_top.sv
// Self-checking bench for axi_st_patchkr_top: one FULL and one HALF instance, random words
// checked against a queue-based expected-beat model.
`timescale 1ns/1ps
module tb_axi_st_patchkr_top;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic f_en = 0, f_cont = 0, f_wr = 0, f_valid = 0;
    logic [8:0] f_cnt = '0;
    logic [39:0] f_exp = '0;
    logic [255:0] f_data = '0;
    logic f_full, f_rdy, f_ovf, f_done, f_pass;
    logic [8:0] f_beat;
    logic [15:0] f_err;

    logic h_en = 0, h_cont = 0, h_wr = 0, h_valid = 0;
    logic [8:0] h_cnt = '0;
    logic [79:0] h_exp = '0;
    logic [511:0] h_data = '0;
    logic h_full, h_rdy, h_ovf, h_done, h_pass;
    logic [8:0] h_beat;
    logic [15:0] h_err;

`ifdef AXIST_CHKR_FIRST_ERR_EN
    logic [255:0] f_fe_data;
    logic [8:0] f_fe_idx;
    logic [511:0] h_fe_data;
    logic [8:0] h_fe_idx;
`endif

    axi_st_patchkr_top #(.LEADER_MODE(1), .FIFO_DEPTH(512), .FIFO_AW(9)) dut_full (
        .clk(clk), .rst_n(rst_n), .chkr_en(f_en), .cntuspatt_en(f_cont),
        .patgen_cnt(f_cnt), .exp_din(f_exp), .exp_wr(f_wr), .chkr_fifo_full(f_full),
        .axist_rx_data(f_data), .axist_rx_valid(f_valid), .axist_rx_rdy(f_rdy),
        .beat_cnt(f_beat), .err_cnt(f_err), .exp_ovf(f_ovf), .chkr_done(f_done),
        .chkr_pass(f_pass)
`ifdef AXIST_CHKR_FIRST_ERR_EN
        , .first_err_data(f_fe_data), .first_err_idx(f_fe_idx)
`endif
    );

    axi_st_patchkr_top #(.LEADER_MODE(2), .FIFO_DEPTH(512), .FIFO_AW(9)) dut_half (
        .clk(clk), .rst_n(rst_n), .chkr_en(h_en), .cntuspatt_en(h_cont),
        .patgen_cnt(h_cnt), .exp_din(h_exp), .exp_wr(h_wr), .chkr_fifo_full(h_full),
        .axist_rx_data(h_data), .axist_rx_valid(h_valid), .axist_rx_rdy(h_rdy),
        .beat_cnt(h_beat), .err_cnt(h_err), .exp_ovf(h_ovf), .chkr_done(h_done),
        .chkr_pass(h_pass)
`ifdef AXIST_CHKR_FIRST_ERR_EN
        , .first_err_data(h_fe_data), .first_err_idx(h_fe_idx)
`endif
    );

    // Reference expansion: six copies of the word topped by its low 16 bits
    function automatic logic [255:0] expand_full(input logic [39:0] e);
        return {e[15:0], e, e, e, e, e, e};
    endfunction

    function automatic logic [511:0] expand_half(input logic [79:0] w);
        return {expand_full(w[79:40]), expand_full(w[39:0])};
    endfunction

    function automatic logic [39:0] rand40();
        return {8'($urandom()), $urandom()};
    endfunction

    function automatic logic [79:0] rand80();
        return {16'($urandom()), $urandom(), $urandom()};
    endfunction

    logic [39:0] fq[$];
    logic [79:0] hq[$];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic f_push(input logic [39:0] w);
        f_exp = w;
        f_wr = 1'b1;
        step();
        f_wr = 1'b0;
    endtask

    task automatic h_push(input logic [79:0] w);
        h_exp = w;
        h_wr = 1'b1;
        step();
        h_wr = 1'b0;
    endtask

    task automatic f_start(input logic [8:0] cnt, input logic cont);
        f_cnt = cnt;
        f_cont = cont;
        f_en = 1'b1;
        step();
    endtask

    task automatic h_start(input logic [8:0] cnt, input logic cont);
        h_cnt = cnt;
        h_cont = cont;
        h_en = 1'b1;
        step();
    endtask

    task automatic f_stop();
        f_en = 1'b0;
        step();
        step();
    endtask

    task automatic h_stop();
        h_en = 1'b0;
        step();
        step();
    endtask

    // Present a beat until accepted (bounded); returns at accept edge + 1
    task automatic f_send(input logic [255:0] d, output bit ok);
        f_data = d;
        f_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (f_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        f_valid = 1'b0;
    endtask

    task automatic h_send(input logic [511:0] d, output bit ok);
        h_data = d;
        h_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (h_rdy) begin
                ok = 1'b1;
                break;
            end
        end
        step();
        h_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({f_beat, f_err, f_ovf, f_done, f_pass, f_full, f_rdy} !== '0)
            begin errors++; $display("FAIL reset_full: got %0h expected 0",
                {f_beat, f_err, f_ovf, f_done, f_pass, f_full, f_rdy}); end
        checks++;
        if ({h_beat, h_err, h_ovf, h_done, h_pass, h_full, h_rdy} !== '0)
            begin errors++; $display("FAIL reset_half: got %0h expected 0",
                {h_beat, h_err, h_ovf, h_done, h_pass, h_full, h_rdy}); end
        rst_n = 1'b1;
        step();
    endtask

    // Eight beats, optionally one with a flipped bit; checks exact DONE timing
    task automatic run_full8(input int flip_beat, input string tag);
        bit ok;
        logic [255:0] d;
        logic [255:0] one;
        logic [255:0] bad_beat;
        int exp_err;
        one = 256'd1;
        bad_beat = '0;
        exp_err = 0;
        f_start(9'd8, 1'b0);
        for (int k = 0; k < 8; k++) begin
            logic [39:0] w;
            w = rand40();
            fq.push_back(w);
            f_push(w);
        end
        for (int k = 0; k < 8; k++) begin
            d = expand_full(fq.pop_front());
            if (k == flip_beat) begin
                d = d ^ (one << 100);
                bad_beat = d;
                exp_err = 1;
            end
            f_send(d, ok);
            checks++;
            if (!ok || f_beat !== 9'(k + 1))
                begin errors++; $display("FAIL %s_beat%0d: ok=%0d beat_cnt=%0d expected %0d",
                    tag, k, ok, f_beat, k + 1); end
        end
        @(negedge clk);
        checks++;
        if (f_done !== 1'b0 || f_beat !== 9'd8)
            begin errors++; $display("FAIL %s_drain: done=%0d beat=%0d expected done=0 beat=8",
                tag, f_done, f_beat); end
        @(negedge clk);
        checks++;
        if (f_done !== 1'b1 || f_err !== 16'(exp_err) || f_pass !== (exp_err == 0))
            begin errors++; $display("FAIL %s_done: done=%0d err=%0d pass=%0d expected 1/%0d/%0d",
                tag, f_done, f_err, f_pass, exp_err, exp_err == 0); end
`ifdef AXIST_CHKR_FIRST_ERR_EN
        checks++;
        if (f_fe_idx !== 9'(exp_err ? flip_beat : 0) || f_fe_data !== bad_beat)
            begin errors++; $display("FAIL %s_first_err: idx=%0d expected %0d", tag, f_fe_idx,
                exp_err ? flip_beat : 0); end
`endif
        f_stop();
    endtask

    task automatic test_match();
        run_full8(-1, "match");
    endtask

    task automatic test_mismatch();
        run_full8(2, "mismatch");
    endtask

    task automatic test_empty_stall();
        logic [39:0] w;
        w = rand40();
        f_start(9'd1, 1'b0);
        f_data = expand_full(w);
        f_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (f_rdy !== 1'b0 || f_beat !== 9'd0)
                begin errors++; $display("FAIL stall_%0d: rdy=%0d beat=%0d expected 0/0",
                    i, f_rdy, f_beat); end
        end
        step();
        f_push(w);
        @(negedge clk);
        checks++;
        if (f_rdy !== 1'b1)
            begin errors++; $display("FAIL stall_rdy: rdy=%0d expected 1", f_rdy); end
        step();
        f_valid = 1'b0;
        checks++;
        if (f_beat !== 9'd1)
            begin errors++; $display("FAIL stall_accept: beat=%0d expected 1", f_beat); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (f_done !== 1'b1 || f_pass !== 1'b1 || f_beat !== 9'd1)
            begin errors++; $display("FAIL stall_done: done=%0d pass=%0d beat=%0d expected 1/1/1",
                f_done, f_pass, f_beat); end
        f_stop();
    endtask

    task automatic test_overflow();
        bit ok;
        bit got;
        f_start(9'd8, 1'b0);
        for (int k = 0; k < 512; k++) begin
            logic [39:0] w;
            w = rand40();
            fq.push_back(w);
            f_push(w);
        end
        checks++;
        if (f_full !== 1'b1 || f_ovf !== 1'b0)
            begin errors++; $display("FAIL ovf_full: full=%0d ovf=%0d expected 1/0", f_full, f_ovf); end
        f_push(rand40());
        checks++;
        if (f_ovf !== 1'b1)
            begin errors++; $display("FAIL ovf_sticky: ovf=%0d expected 1", f_ovf); end
        for (int k = 0; k < 8; k++) begin
            f_send(expand_full(fq.pop_front()), ok);
            checks++;
            if (!ok)
                begin errors++; $display("FAIL ovf_send%0d: timed out waiting for rdy", k); end
        end
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (f_done) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || f_pass !== 1'b0 || f_err !== 16'd0 || f_ovf !== 1'b1)
            begin errors++; $display("FAIL ovf_done: done=%0d pass=%0d err=%0d ovf=%0d expected 1/0/0/1",
                got, f_pass, f_err, f_ovf); end
        f_stop();
        fq.delete();
        checks++;
        if (f_full !== 1'b0 || f_rdy !== 1'b0)
            begin errors++; $display("FAIL ovf_flush: full=%0d rdy=%0d expected 0/0", f_full, f_rdy); end
    endtask

    task automatic test_half();
        bit ok;
        bit got;
        logic [511:0] d;
        logic [511:0] bad_beat;
        logic [79:0] w;
        bad_beat = '0;
        h_start(9'd4, 1'b0);
        for (int k = 0; k < 4; k++) begin
            w = rand80();
            hq.push_back(w);
            h_push(w);
        end
        for (int k = 0; k < 4; k++) begin
            d = expand_half(hq.pop_front());
            if (k == 0) begin
                d[511:496] = d[511:496] ^ 16'($urandom_range(1, 65535));
                bad_beat = d;
            end
            h_send(d, ok);
            checks++;
            if (!ok)
                begin errors++; $display("FAIL half_send%0d: timed out waiting for rdy", k); end
        end
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (h_done) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || h_err !== 16'd1 || h_pass !== 1'b0 || h_beat !== 9'd4)
            begin errors++; $display("FAIL half_tail: done=%0d err=%0d pass=%0d beat=%0d expected 1/1/0/4",
                got, h_err, h_pass, h_beat); end
`ifdef AXIST_CHKR_FIRST_ERR_EN
        checks++;
        if (h_fe_idx !== 9'd0 || h_fe_data !== bad_beat)
            begin errors++; $display("FAIL half_first_err: idx=%0d expected 0", h_fe_idx); end
`endif
        h_stop();
        w = rand80();
        h_push(w);
        h_start(9'd0, 1'b0);
        h_data = expand_half(w);
        h_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (h_rdy !== 1'b0)
            begin errors++; $display("FAIL half_zero_rdy: rdy=%0d expected 0", h_rdy); end
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (h_done) begin got = 1'b1; break; end
        end
        checks++;
        if (!got || h_pass !== 1'b1 || h_beat !== 9'd0 || h_err !== 16'd0)
            begin errors++; $display("FAIL half_zero_done: done=%0d pass=%0d beat=%0d err=%0d expected 1/1/0/0",
                got, h_pass, h_beat, h_err); end
`ifdef AXIST_CHKR_FIRST_ERR_EN
        checks++;
        if (h_fe_idx !== 9'd0 || h_fe_data !== '0)
            begin errors++; $display("FAIL half_zero_first_err: idx=%0d data nonzero=%0d",
                h_fe_idx, h_fe_data != '0); end
`endif
        h_valid = 1'b0;
        h_stop();
    endtask

    task automatic test_continuous();
        bit ok;
        bit done_seen;
        int nerr;
        int fails;
        logic [255:0] d;
        logic [39:0] w;
        nerr = 0;
        fails = 0;
        done_seen = 1'b0;
        f_start(9'd3, 1'b1);
        for (int k = 0; k < 600; k++) begin
            w = rand40();
            f_push(w);
            d = expand_full(w);
            if ($urandom_range(0, 39) == 0) begin
                d[$urandom_range(0, 255)] ^= 1'b1;
                nerr++;
            end
            f_send(d, ok);
            if (!ok) fails++;
            done_seen |= f_done;
        end
        checks++;
        if (fails != 0)
            begin errors++; $display("FAIL cont_send: %0d beats timed out, expected 0", fails); end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (f_beat !== 9'd88 || f_err !== 16'(nerr))
            begin errors++; $display("FAIL cont_counts: beat=%0d err=%0d expected 88/%0d",
                f_beat, f_err, nerr); end
        checks++;
        if (done_seen || f_done !== 1'b0 || f_pass !== 1'b0)
            begin errors++; $display("FAIL cont_done: seen=%0d done=%0d pass=%0d expected 0/0/0",
                done_seen, f_done, f_pass); end
        step();
        w = rand40();
        f_push(w);
        f_data = ~expand_full(w);
        f_valid = 1'b1;
        step();
        f_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({f_beat, f_err, f_ovf, f_done, f_pass, f_full, f_rdy} !== '0)
            begin errors++; $display("FAIL midrun_reset: got %0h expected 0",
                {f_beat, f_err, f_ovf, f_done, f_pass, f_full, f_rdy}); end
        f_en = 1'b0;
        f_cont = 1'b0;
        step();
        rst_n = 1'b1;
        step();
        step();
        checks++;
        if (f_err !== 16'd0 || f_beat !== 9'd0)
            begin errors++; $display("FAIL midrun_discard: err=%0d beat=%0d expected 0/0",
                f_err, f_beat); end
    endtask

    initial begin
        test_reset();
        test_match();
        test_mismatch();
        test_empty_stall();
        test_overflow();
        test_half();
        test_continuous();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
